// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / busy scoreboard.
// Provides the scoreboard population-count helper used to build busy_cnt.
package regfile_pkg;

    // Largest register count the popcount helper accepts.
    localparam int MAX_REGS  = 256;
    localparam int CNT_MAX_W = $clog2(MAX_REGS) + 1;

    // Number of set bits in a (zero-extended) busy vector.
    function automatic logic [CNT_MAX_W-1:0] popcount(input logic [MAX_REGS-1:0] v);
        logic [CNT_MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + CNT_MAX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, busy lookup, zero-register mask
// and (with REGFILE_BYPASS_EN defined) same-cycle write-through from writeback.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0]           regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]         busy_vec,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
`endif
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_busy
);

    // Select stored value, override with in-flight writeback, then mask r0.
    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy_vec[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a busy scoreboard for destination
// registers whose writeback is still in flight. Decode issues (sets busy),
// writeback writes data (clears busy); issue wins on a same-cycle collision.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through reads).
// NUM_REGS must be a power of two between 2 and regfile_pkg::MAX_REGS.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]        wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               iss_en,
    input  logic [$clog2(NUM_REGS)-1:0]        iss_addr,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]           rd_data,
    output logic [NUM_RD-1:0]                  rd_busy,
    output logic [NUM_REGS-1:0]                busy_vec,
    output logic [$clog2(NUM_REGS):0]          busy_cnt
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                wr_ok;
    logic                iss_ok;
    logic [NUM_REGS-1:0] busy_next;
    logic [MAX_REGS-1:0] busy_ext;

    // Accesses to the hard-wired zero register are dropped at the source.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Register storage: async clear, one write per cycle from writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next scoreboard: writeback clears, issue sets afterwards so it has priority.
    always_comb begin
        busy_next = busy_vec;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    // Widen the next scoreboard to the popcount helper's input width.
    always_comb begin
        busy_ext                 = '0;
        busy_ext[NUM_REGS-1:0]   = busy_next;
    end

    // Scoreboard and its count register; count always equals popcount(busy_vec).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
            busy_cnt <= '0;
        end else begin
            busy_vec <= busy_next;
            busy_cnt <= CW'(popcount(busy_ext));
        end
    end

    // Independent read ports, each with its own address slice.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .regs     (regs),
            .busy_vec (busy_vec),
            .rd_addr  (rd_addr[k*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
`endif
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (32 x 32-bit, 4 read ports, zero register on).
// Inputs change on negedge; combinational reads are sampled 1ns later,
// registered state is observed after the following posedge.
module tb_regfile_scoreboard;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 4;
    localparam int AW  = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NR-1:0]     busy_vec;
    logic [AW:0]       busy_cnt;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // reference model: register contents and set of busy registers
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    logic [DW-1:0] exp_q [$];
    int            n_checks;
    int            n_fail;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ie;
        logic [AW-1:0] ia;
        logic [AW-1:0] ra;
        logic [DW-1:0] e_vec;
        logic [AW:0]   e_cnt;
        logic [DW-1:0] e_rd;
    } vec_t;
    vec_t tbl [12];

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && wr_en && (wr_addr == a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_bsy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && wr_en && (wr_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [DW-1:0] exp_vec();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    function automatic int exp_cnt();
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare every output against the model for the currently applied inputs
    task automatic check_all(input string tag);
        for (int k = 0; k < NRD; k++) exp_q.push_back(exp_rd(rd_addr[k*AW +: AW]));
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("%s rd_data%0d", tag, k), rd_data[k*DW +: DW], exp_q.pop_front());
            chk($sformatf("%s rd_busy%0d", tag, k), {31'd0, rd_busy[k]},
                {31'd0, exp_bsy(rd_addr[k*AW +: AW])});
        end
        chk({tag, " busy_vec"}, busy_vec, exp_vec());
        chk({tag, " busy_cnt"}, {26'd0, busy_cnt}, exp_cnt());
    endtask

    // driver: apply one cycle of inputs (called right after a negedge)
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ie, input logic [AW-1:0] ia, input logic [NRD*AW-1:0] ra);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = ra;
        #1;
    endtask

    // clock one edge and advance the model by the scoreboard rules
    task automatic tick();
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        tbl[0]  = '{1'b1, 5'd5,  32'h0000_BEEF, 1'b0, 5'd0, 5'd5,  32'h0000_0000, 6'd0, 32'h0000_BEEF};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 5'd3,  32'h0000_0008, 6'd1, 32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7, 5'd7,  32'h0000_0088, 6'd2, 32'h0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9, 5'd9,  32'h0000_0288, 6'd3, 32'h0};
        tbl[4]  = '{1'b1, 5'd7,  32'h0000_7777, 1'b0, 5'd0, 5'd7,  32'h0000_0208, 6'd2, 32'h0000_7777};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4, 5'd4,  32'h0000_0218, 6'd3, 32'h0};
        tbl[6]  = '{1'b1, 5'd4,  32'h0000_4444, 1'b1, 5'd4, 5'd4,  32'h0000_0218, 6'd3, 32'h0000_4444};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd6, 5'd6,  32'h0000_0258, 6'd4, 32'h0};
        tbl[8]  = '{1'b1, 5'd6,  32'h0000_6666, 1'b1, 5'd2, 5'd6,  32'h0000_021C, 6'd4, 32'h0000_6666};
        tbl[9]  = '{1'b1, 5'd0,  32'h0000_1234, 1'b1, 5'd0, 5'd0,  32'h0000_021C, 6'd4, 32'h0};
        tbl[10] = '{1'b1, 5'd12, 32'h0000_C0C0, 1'b0, 5'd0, 5'd12, 32'h0000_021C, 6'd4, 32'h0000_C0C0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 5'd5,  32'h0000_021C, 6'd4, 32'h0000_BEEF};

        // power-on reset
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // table vectors: apply one cycle, then read back with strobes idle
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, {NRD{tbl[i].ra}});
            check_all($sformatf("tbl%0d_in", i));
            tick();
            drive(1'b0, '0, '0, 1'b0, '0, {NRD{tbl[i].ra}});
            chk($sformatf("tbl%0d rd", i),   rd_data[DW-1:0], tbl[i].e_rd);
            chk($sformatf("tbl%0d vec", i),  busy_vec, tbl[i].e_vec);
            chk($sformatf("tbl%0d cnt", i),  {26'd0, busy_cnt}, {26'd0, tbl[i].e_cnt});
            check_all($sformatf("tbl%0d_out", i));
        end

        // asynchronous reset between edges with registers loaded
        drive(1'b0, '0, '0, 1'b0, '0, {5'd12, 5'd4, 5'd7, 5'd5});
        check_all("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NRD; k++) chk($sformatf("rst rd_data%0d", k), rd_data[k*DW +: DW], 32'h0);
        chk("rst busy_vec", busy_vec, 32'h0);
        chk("rst busy_cnt", {26'd0, busy_cnt}, 32'h0);
        model_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);

        // write r5 and read it on all ports the same cycle and the next
        drive(1'b1, 5'd5, 32'h0000_BEEF, 1'b0, '0, {NRD{5'd5}});
        for (int k = 0; k < NRD; k++)
            chk($sformatf("same_cycle rd_data%0d", k), rd_data[k*DW +: DW], BYP ? 32'h0000_BEEF : 32'h0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, {NRD{5'd5}});
        for (int k = 0; k < NRD; k++)
            chk($sformatf("next_cycle rd_data%0d", k), rd_data[k*DW +: DW], 32'h0000_BEEF);

        // writeback to a busy register: busy visible until the edge unless bypassed
        drive(1'b0, '0, '0, 1'b1, 5'd8, {NRD{5'd8}});
        tick();
        drive(1'b1, 5'd8, 32'h8888_0008, 1'b0, '0, {5'd8, 5'd0, 5'd5, 5'd8});
        chk("wb_busy rd_busy0", {31'd0, rd_busy[0]}, BYP ? 32'd0 : 32'd1);
        chk("wb_busy rd_data0", rd_data[DW-1:0], BYP ? 32'h8888_0008 : 32'h0);
        check_all("wb_busy");
        tick();

        // randomized sweep against the model
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                  1'($urandom_range(0, 1)), rnd_addr(),
                  {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()});
            check_all($sformatf("rnd%0d", c));
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0, {5'd1, 5'd2, 5'd3, 5'd0});
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
